// File: rtl/bird_pkg.sv
// Shared constants for the flappy-bird motion block: state encoding,
// field widths and the default physics tuning.
// Pure declarations, no logic.
package bird_pkg;

  // Field widths of the exported position, velocity and state.
  localparam int Y_W   = 10;
  localparam int VEL_W = 8;
  localparam int ST_W  = 2;

  // State encoding is visible on the state output, so it is fixed.
  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_FLY  = 2'b01;
  localparam logic [ST_W-1:0] ST_DEAD = 2'b10;

  // Default physics: rows in pixels, velocities in pixels per frame.
  localparam int DEF_Y_START  = 240;
  localparam int DEF_Y_MIN    = 0;
  localparam int DEF_Y_MAX    = 464;
  localparam int DEF_FLAP_VEL = -8;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_VMAX     = 10;

  // Narrow an integer row constant to the bird_y field width.
  function automatic logic [Y_W-1:0] to_row(input int v);
    return Y_W'(v);
  endfunction

endpackage

// File: rtl/bird_phys_step.sv
// One frame of bird physics: next velocity, next clamped row, ground/ceiling flags.
// Latency: purely combinational, result is valid in the same cycle as its inputs.
// Backpressure: none; the caller decides whether to register the result.
module bird_phys_step
  import bird_pkg::*;
#(
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int VMAX     = DEF_VMAX
) (
  input  logic [Y_W-1:0]   cur_y,
  input  logic [VEL_W-1:0] cur_vel,
  input  logic             flap_now,
  output logic [Y_W-1:0]   next_y,
  output logic [VEL_W-1:0] next_vel,
  output logic             at_ground,
  output logic             at_ceil
);

  // Velocity math carries one guard bit so vel+GRAVITY cannot wrap before
  // the VMAX saturation is applied.
  localparam logic signed [VEL_W:0] FLAP_S = (VEL_W+1)'(FLAP_VEL);
  localparam logic signed [VEL_W:0] GRAV_S = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0] VMAX_S = (VEL_W+1)'(VMAX);

  // Row math is signed and two bits wider than the row so that a climb past
  // row 0 reads as negative and a fall past the ground cannot wrap.
  localparam logic signed [Y_W+1:0] YMIN_S = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] YMAX_S = (Y_W+2)'(Y_MAX);

  logic signed [VEL_W:0] vel_inc;
  logic signed [VEL_W:0] vel_sel;
  logic signed [Y_W+1:0] y_raw;

  // Pick the new velocity: a flap overrides gravity, otherwise accelerate
  // downwards and saturate at the terminal fall speed.
  always_comb begin
    vel_inc = $signed({cur_vel[VEL_W-1], cur_vel}) + GRAV_S;
    if (flap_now) begin
      vel_sel = FLAP_S;
    end else if (vel_inc > VMAX_S) begin
      vel_sel = VMAX_S;
    end else begin
      vel_sel = vel_inc;
    end
  end

  // Move by the new velocity and clamp to the playfield; touching either
  // boundary stops the bird dead (velocity forced to zero).
  always_comb begin
    y_raw     = $signed({2'b00, cur_y}) + $signed({{3{vel_sel[VEL_W]}}, vel_sel});
    at_ground = (y_raw >= YMAX_S);
    at_ceil   = (y_raw <= YMIN_S);
    next_y    = y_raw[Y_W-1:0];
    next_vel  = vel_sel[VEL_W-1:0];
    if (at_ground) begin
      next_y   = to_row(Y_MAX);
      next_vel = '0;
    end else if (at_ceil) begin
      next_y   = to_row(Y_MIN);
      next_vel = '0;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird position/velocity state machine (IDLE -> FLY -> DEAD -> IDLE); ceiling kill via BIRD_CEIL_KILL_EN.
// Latency: one clock from frame_tick (or hit/flap) to updated bird_y/bird_vel/state.
// Backpressure: none; flap is latched as a pending request until the next frame tick.
module bird_motion
  import bird_pkg::*;
#(
  parameter int Y_START  = DEF_Y_START,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int FLAP_VEL = DEF_FLAP_VEL,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int VMAX     = DEF_VMAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             flap,
  input  logic             hit,
  output logic [Y_W-1:0]   bird_y,
  output logic [VEL_W-1:0] bird_vel,
  output logic [ST_W-1:0]  state,
  output logic             dead_pulse
);

  logic             flap_pending;

  logic [ST_W-1:0]  state_n;
  logic [Y_W-1:0]   y_n;
  logic [VEL_W-1:0] vel_n;
  logic             pend_n;
  logic             pulse_n;

  logic [Y_W-1:0]   step_y;
  logic [VEL_W-1:0] step_vel;
  logic             step_ground;
  logic             step_ceil;

  // A flap arriving on the tick cycle itself counts, so it is ORed with the
  // latched request rather than waiting a frame.
  bird_phys_step #(
    .Y_MIN    (Y_MIN),
    .Y_MAX    (Y_MAX),
    .FLAP_VEL (FLAP_VEL),
    .GRAVITY  (GRAVITY),
    .VMAX     (VMAX)
  ) u_phys (
    .cur_y     (bird_y),
    .cur_vel   (bird_vel),
    .flap_now  (flap_pending | flap),
    .next_y    (step_y),
    .next_vel  (step_vel),
    .at_ground (step_ground),
    .at_ceil   (step_ceil)
  );

  // Next-state decode: hit beats frame_tick in FLY, DEAD freezes everything
  // until a flap restarts the game.
  always_comb begin
    state_n = state;
    y_n     = bird_y;
    vel_n   = bird_vel;
    pend_n  = flap_pending;
    pulse_n = 1'b0;
    case (state)
      ST_IDLE: begin
        y_n   = to_row(Y_START);
        vel_n = '0;
        if (flap) begin
          state_n = ST_FLY;
          pend_n  = 1'b1;
        end
      end
      ST_FLY: begin
        if (hit) begin
          state_n = ST_DEAD;
          pulse_n = 1'b1;
        end else if (frame_tick) begin
          y_n    = step_y;
          vel_n  = step_vel;
          pend_n = 1'b0;
          if (step_ground) begin
            state_n = ST_DEAD;
            pulse_n = 1'b1;
          end
`ifdef BIRD_CEIL_KILL_EN
          else if (step_ceil) begin
            state_n = ST_DEAD;
            pulse_n = 1'b1;
          end
`else
          else if (step_ceil) begin
            // Row and velocity are already clamped; the bird keeps flying.
            state_n = ST_FLY;
          end
`endif
        end else if (flap) begin
          pend_n = 1'b1;
        end
      end
      ST_DEAD: begin
        if (flap) begin
          state_n = ST_IDLE;
          pend_n  = 1'b0;
          y_n     = to_row(Y_START);
          vel_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pend_n  = 1'b0;
        y_n     = to_row(Y_START);
        vel_n   = '0;
      end
    endcase
  end

  // State registers; reset overrides every input in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bird_y       <= to_row(Y_START);
      bird_vel     <= '0;
      flap_pending <= 1'b0;
      dead_pulse   <= 1'b0;
    end else begin
      state        <= state_n;
      bird_y       <= y_n;
      bird_vel     <= vel_n;
      flap_pending <= pend_n;
      dead_pulse   <= pulse_n;
    end
  end

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: vector table, ceiling/ground sequences,
// and a randomized run against a rule-level reference model.
module tb_bird_motion;

`ifdef BIRD_CEIL_KILL_EN
  localparam bit KILL = 1'b1;
`else
  localparam bit KILL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       flap = 1'b0;
  logic       hit = 1'b0;
  logic [9:0] bird_y;
  logic [7:0] bird_vel;
  logic [1:0] state;
  logic       dead_pulse;

  bird_motion dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .flap       (flap),
    .hit        (hit),
    .bird_y     (bird_y),
    .bird_vel   (bird_vel),
    .state      (state),
    .dead_pulse (dead_pulse)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 flying, 2 dead; plain integer physics.
  int m_state = 0;
  int m_y     = 240;
  int m_v     = 0;
  bit m_pend  = 1'b0;
  bit m_pulse = 1'b0;

  task automatic model_step(input bit r, input bit t, input bit f, input bit h);
    m_pulse = 1'b0;
    if (r) begin
      m_state = 0; m_y = 240; m_v = 0; m_pend = 1'b0;
    end else if (m_state == 0) begin
      if (f) begin m_state = 1; m_pend = 1'b1; end
    end else if (m_state == 1) begin
      if (h) begin
        m_state = 2; m_pulse = 1'b1;
      end else if (t) begin
        if (m_pend || f) m_v = -8;
        else m_v = (m_v + 1 > 10) ? 10 : m_v + 1;
        m_y = m_y + m_v;
        m_pend = 1'b0;
        if (m_y >= 464) begin
          m_y = 464; m_v = 0; m_state = 2; m_pulse = 1'b1;
        end else if (m_y <= 0) begin
          m_y = 0; m_v = 0;
          if (KILL) begin m_state = 2; m_pulse = 1'b1; end
        end
      end else if (f) begin
        m_pend = 1'b1;
      end
    end else begin
      if (f) begin m_state = 0; m_y = 240; m_v = 0; m_pend = 1'b0; end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive_cycle(input bit r, input bit t, input bit f, input bit h);
    rst = r; frame_tick = t; flap = f; hit = h;
    @(posedge clk);
    #1;
    model_step(r, t, f, h);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_y"}, int'(bird_y), m_y);
    check({tag, "_vel"}, int'($signed(bird_vel)), m_v);
    check({tag, "_pulse"}, int'(dead_pulse), int'(m_pulse));
  endtask

  typedef struct {
    bit r, t, f, h;
    int st, y, v;
    bit p;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int pulses;
    // inputs r t f h -> expected state, y, vel, dead_pulse
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 240,  0, 1'b0}; // reset
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 240,  0, 1'b0}; // flap in idle
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 232, -8, 1'b0}; // pending flap used
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 225, -7, 1'b0}; // gravity
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 225, -7, 1'b0}; // flap latched
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 225, -7, 1'b0}; // second flap
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 217, -8, 1'b0}; // counted once
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 217, -8, 1'b1}; // hit beats tick
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 217, -8, 1'b0}; // dead frozen
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 217, -8, 1'b0}; // hit in dead
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 240,  0, 1'b0}; // rst+flap in dead
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 240,  0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 240,  0, 1'b1}; // hit kills
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 240,  0, 1'b0}; // flap restarts
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 240,  0, 1'b0}; // tick in idle
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 240,  0, 1'b0}; // hit in idle
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 240,  0, 1'b0}; // tick ignored on entry
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 232, -8, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 240,  0, 1'b0}; // rst mid-fly wins

    for (int i = 0; i < 19; i++) begin
      drive_cycle(tbl[i].r, tbl[i].t, tbl[i].f, tbl[i].h);
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("tbl%0d_y", i), int'(bird_y), tbl[i].y);
      check($sformatf("tbl%0d_vel", i), int'($signed(bird_vel)), tbl[i].v);
      check($sformatf("tbl%0d_pulse", i), int'(dead_pulse), int'(tbl[i].p));
    end

    // Ceiling approach: reach row 210 at vel -4, then flap down to 10, 2, 0.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_model("ceil_coast");
    end
    check("ceil_y210", int'(bird_y), 210);
    for (int i = 0; i < 25; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_model("ceil_climb");
    end
    check("ceil_y10", int'(bird_y), 10);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("ceil_y2", int'(bird_y), 2);
    check("ceil_v2", int'($signed(bird_vel)), -8);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("ceil_y0", int'(bird_y), 0);
    check("ceil_v0", int'($signed(bird_vel)), 0);
    check("ceil_state", int'(state), KILL ? 2 : 1);
    check("ceil_pulse", int'(dead_pulse), KILL ? 1 : 0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("ceil_after_y", int'(bird_y), KILL ? 0 : 1);
    check("ceil_after_v", int'($signed(bird_vel)), KILL ? 0 : 1);
    check("ceil_after_pulse", int'(dead_pulse), 0);

    // Free fall to the ground: velocity saturates at 10, one dead pulse.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_model("fall");
      pulses += int'(dead_pulse);
      if (m_state == 2) break;
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      pulses += int'(dead_pulse);
    end
    check("ground_y", int'(bird_y), 464);
    check("ground_vel", int'($signed(bird_vel)), 0);
    check("ground_state", int'(state), 2);
    check("ground_pulses", pulses, 1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("ground_restart_state", int'(state), 0);
    check("ground_restart_y", int'(bird_y), 240);

    // Randomized traffic against the reference model.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom % 100) < 2, ($urandom % 100) < 30,
                  ($urandom % 100) < 12, ($urandom % 100) < 4);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
